// File: rtl/pc_reg_unit.sv
// Program-counter register stage: holds the fetch address, picks the next PC
// (step / redirect / exception vector) and offers it to fetch via pc_valid/if_ready.
module pc_reg_unit #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = 32'h0040_0000,
    parameter logic [WIDTH-1:0]   EXC_VEC  = 32'h0040_0004,
    parameter int                 STEP     = 4,
    parameter int                 CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             if_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             exc,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             pc_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;

    logic fire;
    logic target_misaligned;

    // Sequential step wraps naturally at 2^WIDTH through the truncated add.
    function automatic logic [WIDTH-1:0] step_pc(input logic [WIDTH-1:0] cur);
        return cur + WIDTH'(STEP);
    endfunction

    assign pc_next_seq       = step_pc(pc);
    assign fire              = pc_valid & if_ready;
    assign target_misaligned = |redir_target[1:0];

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            pc_valid     <= 1'b0;
            misalign_err <= 1'b0;
            fetch_cnt    <= '0;
        end else begin
            misalign_err <= 1'b0;

            // The counter tracks accepted fetches even when a flush wins the pc mux.
            if (fire) begin
                fetch_cnt <= fetch_cnt + 1'b1;
            end

            unique case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end

                RUN, HALT: begin
                    if (exc) begin
                        pc <= EXC_VEC;
                    end else if (redirect) begin
                        if (target_misaligned) begin
                            pc           <= EXC_VEC;
                            misalign_err <= 1'b1;
                        end else begin
                            pc <= redir_target;
                        end
                    end else if (fire) begin
                        pc <= pc_next_seq;
                    end

                    if (state == RUN) begin
                        if (halt && !exc) begin
                            state    <= HALT;
                            pc_valid <= 1'b0;
                        end
                    end else if (resume || exc) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                    end
                end

                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_reg_unit.sv
// Scoreboard bench for pc_reg_unit: driver pushes model expectations, monitor pops and compares.
module tb_pc_reg_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC  = 32'h0040_0004;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        if_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redir_target = '0;
    logic        exc = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        pc_valid;
    logic        misalign_err;
    logic [15:0] fetch_cnt;

    pc_reg_unit dut (
        .CLK(CLK), .RST_n(RST_n), .if_ready(if_ready), .redirect(redirect),
        .redir_target(redir_target), .exc(exc), .halt(halt), .resume(resume),
        .pc(pc), .pc_next_seq(pc_next_seq), .pc_valid(pc_valid),
        .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        longint pc;
        bit     valid;
        bit     mis;
        longint cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;

    // Reference model: fetcher is booting, running or halted.
    bit     m_booting = 1;
    bit     m_halted  = 0;
    longint m_pc      = 0;
    longint m_cnt     = 0;
    bit     m_mis     = 0;

    task automatic model_step();
        bit running, accepted;
        if (!RST_n) begin
            m_pc = RESET_PC; m_booting = 1; m_halted = 0; m_mis = 0; m_cnt = 0;
        end else if (m_booting) begin
            m_booting = 0; m_mis = 0;
        end else begin
            running  = !m_halted;
            accepted = running && if_ready;
            m_mis    = 0;
            if (accepted) m_cnt = (m_cnt + 1) % 65536;
            if (exc) m_pc = EXC_VEC;
            else if (redirect) begin
                if (redir_target % 4 != 0) begin m_pc = EXC_VEC; m_mis = 1; end
                else m_pc = redir_target;
            end else if (accepted) m_pc = (m_pc + 4) % 64'h1_0000_0000;
            if (running && halt && !exc) m_halted = 1;
            else if (m_halted && (resume || exc)) m_halted = 0;
        end
    endtask

    task automatic cyc(input bit rn, input bit rdy, input bit rd, input logic [31:0] tgt,
                       input bit ex, input bit hl, input bit rs);
        exp_t e;
        @(negedge CLK);
        RST_n = rn; if_ready = rdy; redirect = rd; redir_target = tgt;
        exc = ex; halt = hl; resume = rs;
        model_step();
        e.pc = m_pc; e.valid = !m_booting && !m_halted; e.mis = m_mis; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a new pc every cycle once the model is defined.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_valid", pc_valid, e.valid);
                chk("sb_misalign", misalign_err, e.mis);
                chk("sb_fetch_cnt", fetch_cnt, e.cnt);
                chk("sb_pc_next_seq", pc_next_seq, (e.pc + 4) % 64'h1_0000_0000);
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        // 1: reset hold then release
        repeat (3) cyc(0, 1, 1, 32'h1234_5678, 1, 1, 1);
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_valid", pc_valid, 0);
        chk("rst_cnt", fetch_cnt, 0);
        chk("rst_mis", misalign_err, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("boot_valid", pc_valid, 1);
        chk("boot_pc", pc, 32'h0040_0000);
        // 2: sequential fetch then stall
        repeat (4) cyc(1, 1, 0, 0, 0, 0, 0);
        chk("seq_pc", pc, 32'h0040_0010);
        chk("seq_cnt", fetch_cnt, 4);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("stall_pc", pc, 32'h0040_0010);
        chk("stall_cnt", fetch_cnt, 4);
        // 3: aligned and misaligned redirect
        cyc(1, 0, 1, 32'h0040_0100, 0, 0, 0);
        chk("redir_pc", pc, 32'h0040_0100);
        cyc(1, 0, 1, 32'h0040_0102, 0, 0, 0);
        chk("misredir_pc", pc, 32'h0040_0004);
        chk("misredir_pulse", misalign_err, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("misredir_pulse_end", misalign_err, 0);
        // 4: exception beats redirect
        cyc(1, 0, 1, 32'h0040_0200, 1, 0, 0);
        chk("exc_pc", pc, 32'h0040_0004);
        chk("exc_no_mis", misalign_err, 0);
        // 5: halt, redirect while halted, resume
        cyc(1, 0, 0, 0, 0, 1, 0);
        chk("halt_valid", pc_valid, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("halt_frozen_pc", pc, 32'h0040_0004);
        chk("halt_frozen_cnt", fetch_cnt, 4);
        cyc(1, 1, 1, 32'h0040_0300, 0, 0, 0);
        chk("halt_redir_pc", pc, 32'h0040_0300);
        chk("halt_redir_valid", pc_valid, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("resume_valid", pc_valid, 1);
        // 6: wrap and reset mid-run
        cyc(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        chk("pre_wrap_next_seq", pc_next_seq, 32'h0000_0000);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_cnt", fetch_cnt, 5);
        cyc(0, 1, 1, 32'h0040_0800, 0, 0, 0);
        chk("midrst_pc", pc, 32'h0040_0000);
        chk("midrst_cnt", fetch_cnt, 0);
        chk("midrst_valid", pc_valid, 0);

        // Randomized traffic, occasional resets, near-wrap and misaligned targets.
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) tgt[31:4] = 28'hFFF_FFFF;
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 5) == 0), tgt, ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
        end

        @(negedge CLK);
        done = 1;
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
